// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one synchronous memory port
//               between the CPU load/store path (requester 0) and the
//               debug/program loader (requester 1). Each grant runs one
//               latched transaction and ends with a one-cycle ack pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active low
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [1:0]        gnt,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_w_data,
    input  logic [DATA_W-1:0] m_r_data
);

    // A latency counter of two bits cannot represent more than three cycles.
    generate
        if (RD_LAT < 0 || RD_LAT > 3) begin : g_bad_rd_lat
            $error("mem_port_arbiter: RD_LAT must be within 0..3");
        end
    endgenerate

    localparam logic [1:0] c_rd_lat    = 2'(RD_LAT);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_wait   = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [1:0]        w_win;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;

    logic [1:0]        r_gnt;
    logic [1:0]        r_ack;
    logic              r_last_gnt;    // index of the requester served last
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_lat_cnt;
    logic              r_busy;
    logic              r_mem_en;
    logic              r_mem_write;

    // Winner selection in IDLE and next-state decode for the transaction FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_win       = 2'b00;
        case (r_state)
            c_st_idle: begin
                case (req)
                    2'b01:   w_win = 2'b01;
                    2'b10:   w_win = 2'b10;
                    // On a tie the requester that was not served last wins.
                    2'b11:   w_win = r_last_gnt ? 2'b01 : 2'b10;
                    default: w_win = 2'b00;
                endcase
                if (w_win != 2'b00) begin
                    w_state_nxt = c_st_access;
                end
            end
            c_st_access: begin
                if (r_we || (RD_LAT == 0)) begin
                    w_state_nxt = c_st_done;
                end else begin
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                if (r_lat_cnt == 2'd1) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                // req is deliberately ignored here, forcing one IDLE cycle.
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign w_win_we    = |(w_win & we);
    assign w_win_addr  = w_win[1] ? addr1  : addr0;
    assign w_win_wdata = w_win[1] ? wdata1 : wdata0;

    // State register plus every registered output; reset aborts any transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_gnt       <= 2'b00;
            r_ack       <= 2'b00;
            r_last_gnt  <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_lat_cnt   <= 2'd0;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != c_st_idle);
            r_mem_en    <= (w_state_nxt == c_st_access);
            r_mem_write <= 1'b0;
            r_ack       <= (w_state_nxt == c_st_done) ? r_gnt : 2'b00;
            case (r_state)
                c_st_idle: begin
                    if (w_state_nxt == c_st_access) begin
                        r_gnt       <= w_win;
                        r_we        <= w_win_we;
                        r_addr      <= w_win_addr;
                        r_wdata     <= w_win_wdata;
                        r_mem_write <= w_win_we;
                    end
                end
                c_st_access: begin
                    if (!r_we) begin
                        if (RD_LAT == 0) begin
                            r_rdata <= m_r_data;
                        end else begin
                            r_lat_cnt <= c_rd_lat;
                        end
                    end
                end
                c_st_wait: begin
                    r_lat_cnt <= r_lat_cnt - 2'd1;
                    if (r_lat_cnt == 2'd1) begin
                        r_rdata <= m_r_data;
                    end
                end
                c_st_done: begin
                    r_last_gnt <= r_gnt[1];
                    r_gnt      <= 2'b00;
                end
                default: begin
                    r_gnt <= 2'b00;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign gnt       = r_gnt;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign mem_en    = r_mem_en;
    assign mem_write = r_mem_write;
    assign m_addr    = r_addr;
    assign m_w_data  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Three instances
//               (RD_LAT = 1, 0, 3) each talk to a small memory model whose
//               read data is only valid RD_LAT cycles after the access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        mem_clr;
    logic        rst_n    [3];
    logic [1:0]  req      [3];
    logic [1:0]  we       [3];
    logic [31:0] addr0    [3];
    logic [31:0] addr1    [3];
    logic [31:0] wdata0   [3];
    logic [31:0] wdata1   [3];
    logic [1:0]  ack      [3];
    logic [1:0]  gnt      [3];
    logic [31:0] rdata    [3];
    logic        busy     [3];
    logic        mem_en   [3];
    logic        mem_write[3];
    logic [31:0] m_addr   [3];
    logic [31:0] m_w_data [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_inst
        localparam int L = (k == 0) ? 1 : ((k == 1) ? 0 : 3);
        logic [31:0] mem  [256];
        logic [31:0] pipe [4];
        logic [31:0] rd_l;

        // Memory model: writes on the strobe, reads emerge L cycles later.
        always @(posedge clk) begin
            if (mem_clr) begin
                for (int i = 0; i < 256; i++) mem[i] <= '0;
                for (int i = 0; i < 4; i++) pipe[i] <= 32'hBAD0BAD0;
            end else begin
                if (mem_en[k] && mem_write[k]) mem[m_addr[k][7:0]] <= m_w_data[k];
                pipe[0] <= (mem_en[k] && !mem_write[k]) ? mem[m_addr[k][7:0]] : 32'hBAD0BAD0;
                for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
            end
        end

        assign rd_l = (L == 0) ? ((mem_en[k] && !mem_write[k]) ? mem[m_addr[k][7:0]] : 32'hBAD0BAD0)
                               : pipe[(L == 0) ? 0 : L - 1];

        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(L)) u_dut (
            .clk      (clk),
            .rst      (rst_n[k]),
            .req      (req[k]),
            .we       (we[k]),
            .addr0    (addr0[k]),
            .addr1    (addr1[k]),
            .wdata0   (wdata0[k]),
            .wdata1   (wdata1[k]),
            .ack      (ack[k]),
            .gnt      (gnt[k]),
            .rdata    (rdata[k]),
            .busy     (busy[k]),
            .mem_en   (mem_en[k]),
            .mem_write(mem_write[k]),
            .m_addr   (m_addr[k]),
            .m_w_data (m_w_data[k]),
            .m_r_data (rd_l)
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // One transaction from an IDLE negedge; returns at the next IDLE negedge.
    task automatic txn(input int k, input logic [1:0] r, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] eg, input int elat, input logic [31:0] erd,
                       input bit drop_all, input string tag);
        int n_en;
        bit got;
        logic ew;
        ew = |(eg & w);
        req[k] = r; we[k] = w; addr0[k] = a0; addr1[k] = a1; wdata0[k] = d0; wdata1[k] = d1;
        n_en = 0;
        got  = 1'b0;
        for (int i = 1; i <= 12 && !got; i++) begin
            @(negedge clk);
            if (mem_en[k]) n_en++;
            check({tag, " gnt_both"}, 64'(gnt[k] == 2'b11), 64'd0);
            if (i == 1) begin
                check({tag, " gnt_access"}, 64'(gnt[k]), 64'(eg));
                check({tag, " mem_en"}, 64'(mem_en[k]), 64'd1);
                check({tag, " mem_write"}, 64'(mem_write[k]), 64'(ew));
                check({tag, " m_addr"}, 64'(m_addr[k]), 64'(eg[1] ? a1 : a0));
                if (ew) check({tag, " m_w_data"}, 64'(m_w_data[k]), 64'(eg[1] ? d1 : d0));
            end
            if (ack[k] != 2'b00) begin
                got = 1'b1;
                check({tag, " ack"}, 64'(ack[k]), 64'(eg));
                check({tag, " latency"}, 64'(i), 64'(elat));
                check({tag, " gnt_done"}, 64'(gnt[k]), 64'(eg));
                check({tag, " rdata"}, 64'(rdata[k]), 64'(erd));
                req[k] = drop_all ? 2'b00 : (r & ~eg);
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: actual no ack required ack %0h", tag, eg);
            req[k] = 2'b00;
        end
        check({tag, " mem_en_cycles"}, 64'(n_en), 64'd1);
        @(negedge clk);
        check({tag, " idle_busy"}, 64'(busy[k]), 64'd0);
        check({tag, " idle_gnt"}, 64'(gnt[k]), 64'd0);
        check({tag, " idle_ack"}, 64'(ack[k]), 64'd0);
    endtask

    // Holds req steady across n transactions and checks order and spacing.
    task automatic held_seq(input int k, input logic [1:0] r, input logic [1:0] w,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] erd0, input logic [31:0] erd1,
                            input int n, input int first, input int period, input string tag);
        int nacks;
        int last_t;
        int idle_cnt;
        logic [1:0] eg;
        nacks = 0; last_t = 0; idle_cnt = 0;
        req[k] = r; we[k] = w; addr0[k] = a0; addr1[k] = a1; wdata0[k] = d0; wdata1[k] = d1;
        for (int t = 1; t <= 60 && nacks < n; t++) begin
            @(negedge clk);
            check({tag, " gnt_both"}, 64'(gnt[k] == 2'b11), 64'd0);
            if (!busy[k]) idle_cnt++;
            if (ack[k] != 2'b00) begin
                eg = (r == 2'b11) ? ((nacks % 2 == 0) ? 2'b01 : 2'b10) : r;
                check({tag, " ack"}, 64'(ack[k]), 64'(eg));
                check({tag, " rdata"}, 64'(rdata[k]), 64'(eg[1] ? erd1 : erd0));
                check({tag, " spacing"}, 64'(t - last_t), 64'((nacks == 0) ? first : period));
                if (nacks > 0) check({tag, " idle_cycles"}, 64'(idle_cnt), 64'd1);
                idle_cnt = 0;
                nacks++;
                last_t = t;
            end
        end
        check({tag, " ack_count"}, 64'(nacks), 64'(n));
        req[k] = 2'b00;
        @(negedge clk);
        check({tag, " idle_busy"}, 64'(busy[k]), 64'd0);
    endtask

    task automatic do_reset(input int k);
        @(negedge clk);
        rst_n[k] = 1'b0;
        req[k]   = 2'b00;
        @(negedge clk);
        rst_n[k] = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  r;
        logic [1:0]  w;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  eg;
        int          lat;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl [11];

    // Reference model state for the randomized phase.
    logic [31:0] model_mem [int];
    logic [1:0]  pend;
    logic        pw [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    int          last_win;
    int          win;
    logic [31:0] model_rd;

    initial begin
        tbl[0]  = '{2'b01, 2'b01, 32'h10, 32'h00, 32'hDEADBEEF, 32'h0, 2'b01, 2, 32'h0};
        tbl[1]  = '{2'b10, 2'b00, 32'h00, 32'h10, 32'h0, 32'h0, 2'b10, 3, 32'hDEADBEEF};
        tbl[2]  = '{2'b01, 2'b00, 32'h10, 32'h00, 32'h0, 32'h0, 2'b01, 3, 32'hDEADBEEF};
        tbl[3]  = '{2'b01, 2'b01, 32'h20, 32'h00, 32'h0BADF00D, 32'h0, 2'b01, 2, 32'hDEADBEEF};
        tbl[4]  = '{2'b01, 2'b00, 32'h20, 32'h00, 32'h0, 32'h0, 2'b01, 3, 32'h0BADF00D};
        tbl[5]  = '{2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0, 2'b10, 3, 32'h0BADF00D};
        tbl[6]  = '{2'b11, 2'b11, 32'h30, 32'h31, 32'h11111111, 32'h22222222, 2'b01, 2, 32'h0BADF00D};
        tbl[7]  = '{2'b11, 2'b00, 32'h30, 32'h10, 32'h0, 32'h0, 2'b10, 3, 32'hDEADBEEF};
        tbl[8]  = '{2'b11, 2'b00, 32'h30, 32'h31, 32'h0, 32'h0, 2'b01, 3, 32'h11111111};
        tbl[9]  = '{2'b10, 2'b10, 32'h00, 32'h31, 32'h0, 32'hCAFEF00D, 2'b10, 2, 32'h11111111};
        tbl[10] = '{2'b11, 2'b00, 32'h31, 32'h30, 32'h0, 32'h0, 2'b01, 3, 32'hCAFEF00D};

        mem_clr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; req[k] = 2'b11; we[k] = 2'b11;
            addr0[k] = 32'h5; addr1[k] = 32'h6; wdata0[k] = 32'h7; wdata1[k] = 32'h8;
        end
        repeat (3) @(negedge clk);
        // Outputs must stay at reset values even with requests asserted.
        for (int k = 0; k < 3; k++) begin
            check("reset ack", 64'(ack[k]), 64'd0);
            check("reset gnt", 64'(gnt[k]), 64'd0);
            check("reset busy", 64'(busy[k]), 64'd0);
            check("reset mem_en", 64'(mem_en[k]), 64'd0);
            check("reset mem_write", 64'(mem_write[k]), 64'd0);
            check("reset m_addr", 64'(m_addr[k]), 64'd0);
            check("reset m_w_data", 64'(m_w_data[k]), 64'd0);
            check("reset rdata", 64'(rdata[k]), 64'd0);
            req[k] = 2'b00; we[k] = 2'b00;
        end
        mem_clr = 1'b0;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            txn(0, tbl[v].r, tbl[v].w, tbl[v].a0, tbl[v].a1, tbl[v].d0, tbl[v].d1,
                tbl[v].eg, tbl[v].lat, tbl[v].erd, 1'b1, $sformatf("tbl%0d", v));
        end

        // Contention: both requesters read, req held at 11 for four transfers.
        do_reset(0);
        held_seq(0, 2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0,
                 32'hDEADBEEF, 32'h0BADF00D, 4, 3, 4, "contend");

        // Requester 0 alone, writes back to back; rdata must not move.
        held_seq(0, 2'b01, 2'b01, 32'h50, 32'h0, 32'h55555555, 32'h0,
                 32'h0BADF00D, 32'h0BADF00D, 3, 2, 3, "b2b");

        // Reset during the ACCESS cycle of a write.
        req[0] = 2'b01; we[0] = 2'b01; addr0[0] = 32'h60; wdata0[0] = 32'h66666666;
        @(negedge clk);
        check("rst_access pre mem_write", 64'(mem_write[0]), 64'd1);
        #2 rst_n[0] = 1'b0;
        #1;
        check("rst_access mem_write", 64'(mem_write[0]), 64'd0);
        check("rst_access mem_en", 64'(mem_en[0]), 64'd0);
        check("rst_access busy", 64'(busy[0]), 64'd0);
        check("rst_access gnt", 64'(gnt[0]), 64'd0);
        @(negedge clk);
        check("rst_access ack", 64'(ack[0]), 64'd0);
        req[0] = 2'b10; we[0] = 2'b00; addr1[0] = 32'h10;
        rst_n[0] = 1'b1;
        // Reset during WAIT of a read by requester 1.
        @(negedge clk);
        @(negedge clk);
        check("rst_wait pre busy", 64'(busy[0]), 64'd1);
        check("rst_wait pre gnt", 64'(gnt[0]), 64'd2);
        #2 rst_n[0] = 1'b0;
        #1;
        check("rst_wait busy", 64'(busy[0]), 64'd0);
        check("rst_wait gnt", 64'(gnt[0]), 64'd0);
        check("rst_wait mem_en", 64'(mem_en[0]), 64'd0);
        check("rst_wait ack", 64'(ack[0]), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold ack", 64'(ack[0]), 64'd0);
        end
        rst_n[0] = 1'b1;
        txn(0, 2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0, 2'b01, 3, 32'hDEADBEEF, 1'b1, "rst_after");
        check("rst_after mem60", 64'(g_inst[0].mem[8'h60]), 64'd0);

        // Latency sweep on the RD_LAT=0 and RD_LAT=3 instances.
        txn(1, 2'b01, 2'b01, 32'h40, 32'h0, 32'h12345678, 32'h0, 2'b01, 2, 32'h0, 1'b1, "lat0 wr");
        txn(1, 2'b10, 2'b00, 32'h0, 32'h40, 32'h0, 32'h0, 2'b10, 2, 32'h12345678, 1'b1, "lat0 rd");
        txn(2, 2'b01, 2'b01, 32'h40, 32'h0, 32'h12345678, 32'h0, 2'b01, 2, 32'h0, 1'b1, "lat3 wr");
        txn(2, 2'b10, 2'b00, 32'h0, 32'h40, 32'h0, 32'h0, 2'b10, 5, 32'h12345678, 1'b1, "lat3 rd");

        // Randomized traffic against a transaction-level reference model.
        do_reset(0);
        pend = 2'b00;
        last_win = 1;
        model_rd = 32'h0;
        for (int j = 0; j < 2; j++) begin
            pw[j] = 1'b0; pa[j] = 32'h80; pd[j] = 32'h0;
        end
        for (int n = 0; n < 40; n++) begin
            for (int j = 0; j < 2; j++) begin
                if (!pend[j] && ($urandom_range(0, 1) == 1)) begin
                    pend[j] = 1'b1;
                    pw[j]   = 1'($urandom_range(0, 1));
                    pa[j]   = 32'h80 + 32'($urandom_range(0, 15));
                    pd[j]   = $urandom;
                end
            end
            if (pend == 2'b00) begin
                win = int'($urandom_range(0, 1));
                pend[win] = 1'b1;
                pw[win]   = 1'b0;
                pa[win]   = 32'h80 + 32'($urandom_range(0, 15));
                pd[win]   = $urandom;
            end
            if (pend == 2'b11) win = 1 - last_win;
            else               win = pend[1] ? 1 : 0;
            if (pw[win]) begin
                model_mem[int'(pa[win])] = pd[win];
            end else begin
                model_rd = model_mem.exists(int'(pa[win])) ? model_mem[int'(pa[win])] : 32'h0;
            end
            txn(0, pend, {pw[1], pw[0]}, pa[0], pa[1], pd[0], pd[1],
                2'(2'b01 << win), pw[win] ? 2 : 3, model_rd, 1'b0, $sformatf("rand%0d", n));
            pend[win] = 1'b0;
            last_win  = win;
        end
        req[0] = 2'b00;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case a wait above never returns.
    initial begin
        #300000;
        $display("FAIL watchdog: actual time limit reached required summary before limit");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
`default_nettype wire
